// File: rtl/mpf_active_req_tracker_pkg.sv
// ---------------------------------------------------------------------------
// mpf_active_req_tracker_pkg
// Shared types and helpers for the active request tracker.
//   t_drain_state : drain FSM encoding (IDLE, DRAIN, DONE)
//   count_width() : per-channel counter width. The extra bit above
//                   $clog2(MAX_ACTIVE) lets a count rise past the soft limit.
// ---------------------------------------------------------------------------
package mpf_active_req_tracker_pkg;

    typedef enum logic [1:0] {
        DS_IDLE  = 2'd0,
        DS_DRAIN = 2'd1,
        DS_DONE  = 2'd2
    } t_drain_state;

    function automatic int count_width(input int max_active);
        return $clog2(max_active) + 1;
    endfunction

endpackage

// File: rtl/mpf_active_req_tracker_if.sv
// ---------------------------------------------------------------------------
// mpf_active_req_tracker_if
// Bundles the tracker's event inputs and status outputs.
//   incr/decr      : per-channel issue / retire strobes
//   drain_req      : level request to quiesce all channels
//   stats_clr      : pulse, resets peak counters to the current counts
//   not_empty      : per-channel outstanding-request flag
//   block          : per-channel "stop issuing" flag
//   drain_ack      : all channels drained while blocked
//   err_underflow  : sticky per-channel underflow flags
//   err_overflow   : sticky per-channel saturation flags
//   peak_cnt       : per-channel high-water marks, channel i at [i*CW +: CW]
// Modports: master = event producer, slave = tracker.
// ---------------------------------------------------------------------------
interface mpf_active_req_tracker_if
    import mpf_active_req_tracker_pkg::*;
#(
    parameter int N_CHANNELS = 2,
    parameter int MAX_ACTIVE = 1024
) ();
    localparam int CW = count_width(MAX_ACTIVE);

    logic [N_CHANNELS-1:0]    incr;
    logic [N_CHANNELS-1:0]    decr;
    logic                     drain_req;
    logic                     stats_clr;
    logic [N_CHANNELS-1:0]    not_empty;
    logic [N_CHANNELS-1:0]    block;
    logic                     drain_ack;
    logic [N_CHANNELS-1:0]    err_underflow;
    logic [N_CHANNELS-1:0]    err_overflow;
    logic [N_CHANNELS*CW-1:0] peak_cnt;

    modport master (
        output incr, decr, drain_req, stats_clr,
        input  not_empty, block, drain_ack, err_underflow, err_overflow, peak_cnt
    );

    modport slave (
        input  incr, decr, drain_req, stats_clr,
        output not_empty, block, drain_ack, err_underflow, err_overflow, peak_cnt
    );
endinterface

// File: rtl/mpf_active_req_tracker_counter.sv
// ---------------------------------------------------------------------------
// mpf_active_req_counter
// One channel of the tracker: saturating up/down count, registered
// not-empty flag, soft-limit compare, sticky error flags and an optional
// high-water mark (compiled in by MPF_ACTIVE_TRACKER_STATS_EN).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_incr, i_decr  : issue / retire strobes
//   i_stats_clr     : reload the peak with the current count
//   o_not_empty     : count != 0 (registered)
//   o_at_limit      : count >= MAX_ACTIVE (from the count register)
//   o_err_underflow : sticky, decrement seen at count 0
//   o_err_overflow  : sticky, increment seen at full-scale count
//   o_peak          : high-water mark (0 when stats are compiled out)
// ---------------------------------------------------------------------------
module mpf_active_req_counter
    import mpf_active_req_tracker_pkg::*;
#(
    parameter int MAX_ACTIVE = 1024,
    parameter int CW         = count_width(MAX_ACTIVE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_incr,
    input  logic          i_decr,
    input  logic          i_stats_clr,
    output logic          o_not_empty,
    output logic          o_at_limit,
    output logic          o_err_underflow,
    output logic          o_err_overflow,
    output logic [CW-1:0] o_peak
);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_ACTIVE);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_underflow;
    logic          w_overflow;
    logic          r_not_empty;
    logic          r_err_underflow;
    logic          r_err_overflow;

    // Simultaneous incr and decr cancel out; the ends of the range hold.
    always_comb begin
        w_count_next = r_count;
        w_underflow  = 1'b0;
        w_overflow   = 1'b0;
        if (i_incr && !i_decr) begin
            if (r_count == '1) w_overflow = 1'b1;
            else               w_count_next = r_count + CW'(1);
        end else if (i_decr && !i_incr) begin
            if (r_count == '0) w_underflow = 1'b1;
            else               w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count         <= '0;
            r_not_empty     <= 1'b0;
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            r_count         <= w_count_next;
            r_not_empty     <= (w_count_next != '0);
            r_err_underflow <= r_err_underflow | w_underflow;
            r_err_overflow  <= r_err_overflow  | w_overflow;
        end
    end

    assign o_not_empty     = r_not_empty;
    assign o_at_limit      = (r_count >= LIMIT);
    assign o_err_underflow = r_err_underflow;
    assign o_err_overflow  = r_err_overflow;

`ifdef MPF_ACTIVE_TRACKER_STATS_EN
    logic [CW-1:0] r_peak;

    // stats_clr restarts the high-water mark from the current occupancy.
    always_ff @(posedge clk) begin
        if (reset)                      r_peak <= '0;
        else if (i_stats_clr)           r_peak <= r_count;
        else if (w_count_next > r_peak) r_peak <= w_count_next;
    end

    assign o_peak = r_peak;
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = i_stats_clr;
    assign o_peak             = '0;
`endif

endmodule

// File: rtl/mpf_active_req_tracker.sv
// ---------------------------------------------------------------------------
// mpf_active_req_tracker
// Tracks outstanding requests on N_CHANNELS independent channels and
// provides back-pressure plus a drain handshake.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : mpf_active_req_tracker_if.slave (events in, status out)
// Parameters: N_CHANNELS (1..8), MAX_ACTIVE (soft per-channel limit, >=2).
// Optional feature: define MPF_ACTIVE_TRACKER_STATS_EN for per-channel
// peak counters; otherwise peak_cnt is tied to 0.
// ---------------------------------------------------------------------------
module mpf_active_req_tracker
    import mpf_active_req_tracker_pkg::*;
#(
    parameter int N_CHANNELS = 2,
    parameter int MAX_ACTIVE = 1024
) (
    input logic                      clk,
    input logic                      reset,
    mpf_active_req_tracker_if.slave  bus
);
    localparam int CW = count_width(MAX_ACTIVE);

    logic [N_CHANNELS-1:0]    w_not_empty;
    logic [N_CHANNELS-1:0]    w_at_limit;
    logic [N_CHANNELS-1:0]    w_err_underflow;
    logic [N_CHANNELS-1:0]    w_err_overflow;
    logic [N_CHANNELS*CW-1:0] w_peak;

    t_drain_state r_state;
    t_drain_state w_state_next;
    logic         w_quiet;

    genvar gi;
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
            mpf_active_req_counter #(
                .MAX_ACTIVE (MAX_ACTIVE),
                .CW         (CW)
            ) u_counter (
                .clk             (clk),
                .reset           (reset),
                .i_incr          (bus.incr[gi]),
                .i_decr          (bus.decr[gi]),
                .i_stats_clr     (bus.stats_clr),
                .o_not_empty     (w_not_empty[gi]),
                .o_at_limit      (w_at_limit[gi]),
                .o_err_underflow (w_err_underflow[gi]),
                .o_err_overflow  (w_err_overflow[gi]),
                .o_peak          (w_peak[gi*CW +: CW])
            );
        end
    endgenerate

    // Drained only when every count is zero and nothing is in flight this
    // cycle, so an event on the final cycle cannot slip past the ack.
    assign w_quiet = (w_not_empty == '0) && (bus.incr == '0) && (bus.decr == '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DS_IDLE:  if (bus.drain_req) w_state_next = DS_DRAIN;
            DS_DRAIN: begin
                if (!bus.drain_req) w_state_next = DS_IDLE;
                else if (w_quiet)   w_state_next = DS_DONE;
            end
            DS_DONE:  if (!bus.drain_req) w_state_next = DS_IDLE;
            default:  w_state_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= DS_IDLE;
        else       r_state <= w_state_next;
    end

    assign bus.not_empty     = w_not_empty;
    assign bus.block         = w_at_limit | {N_CHANNELS{r_state != DS_IDLE}};
    assign bus.drain_ack     = (r_state == DS_DONE);
    assign bus.err_underflow = w_err_underflow;
    assign bus.err_overflow  = w_err_overflow;
    assign bus.peak_cnt      = w_peak;

endmodule

// File: tb/tb_mpf_active_req_tracker.sv
// ---------------------------------------------------------------------------
// tb_mpf_active_req_tracker
// Directed bench for mpf_active_req_tracker with MAX_ACTIVE=4, N_CHANNELS=2.
// Expected values are queued as each step is driven and popped/compared
// after the clock edge that should produce them.
// ---------------------------------------------------------------------------
module tb_mpf_active_req_tracker;
    localparam int NCH  = 2;
    localparam int MAXA = 4;
    localparam int CW   = 3;

`ifdef MPF_ACTIVE_TRACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int S_NE  = 0;
    localparam int S_BLK = 1;
    localparam int S_ACK = 2;
    localparam int S_UF  = 3;
    localparam int S_OF  = 4;
    localparam int S_PK  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mpf_active_req_tracker_if #(.N_CHANNELS(NCH), .MAX_ACTIVE(MAXA)) bus ();

    mpf_active_req_tracker #(
        .N_CHANNELS (NCH),
        .MAX_ACTIVE (MAXA)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } t_exp;

    t_exp sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_NE:    return 32'(bus.not_empty);
            S_BLK:   return 32'(bus.block);
            S_ACK:   return 32'(bus.drain_ack);
            S_UF:    return 32'(bus.err_underflow);
            S_OF:    return 32'(bus.err_overflow);
            S_PK:    return 32'(bus.peak_cnt);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] exp);
        t_exp e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check_pending();
        t_exp        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_tests++;
            $display("[TB] t=%0t %s observed=%0h expected=%0h", $time, e.tag, obs, e.exp);
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.incr      = '0;
        bus.decr      = '0;
        bus.drain_req = 1'b0;
        bus.stats_clr = 1'b0;

        // Reset with events present: they must be ignored.
        reset    = 1'b1;
        bus.incr = 2'b11;
        bus.decr = 2'b10;
        tick(2);
        bus.incr = '0;
        bus.decr = '0;
        reset    = 1'b0;
        expect_val("rst_not_empty", S_NE, 0);
        expect_val("rst_block", S_BLK, 0);
        expect_val("rst_drain_ack", S_ACK, 0);
        expect_val("rst_err_uf", S_UF, 0);
        expect_val("rst_err_of", S_OF, 0);
        expect_val("rst_peak", S_PK, 0);
        check_pending();

        // Fill ch0 up to the limit.
        bus.incr = 2'b01;
        tick(3);
        expect_val("ch0_cnt3_block", S_BLK, 2'b00);
        expect_val("ch0_cnt3_not_empty", S_NE, 2'b01);
        check_pending();
        tick(1);
        expect_val("ch0_cnt4_block", S_BLK, 2'b01);
        expect_val("ch0_cnt4_not_empty", S_NE, 2'b01);
        check_pending();

        // Blocked increments still counted, up to saturation at 7.
        tick(3);
        expect_val("ch0_cnt7_no_of", S_OF, 2'b00);
        check_pending();
        tick(1);
        bus.incr = '0;
        expect_val("ch0_sat_of", S_OF, 2'b01);
        check_pending();

        // Drain ch0 from 7: block drops at 3, not_empty drops at 0.
        bus.decr = 2'b01;
        tick(3);
        expect_val("ch0_cnt4_still_block", S_BLK, 2'b01);
        check_pending();
        tick(1);
        expect_val("ch0_cnt3_unblock", S_BLK, 2'b00);
        check_pending();
        tick(2);
        expect_val("ch0_cnt1_not_empty", S_NE, 2'b01);
        check_pending();
        tick(1);
        bus.decr = '0;
        expect_val("ch0_cnt0_empty", S_NE, 2'b00);
        expect_val("ch0_no_uf", S_UF, 2'b00);
        check_pending();

        // ch1 to 3, then simultaneous incr+decr holds the count.
        bus.incr = 2'b10;
        tick(3);
        expect_val("ch1_cnt3_not_empty", S_NE, 2'b10);
        check_pending();
        bus.decr = 2'b10;
        tick(1);
        bus.decr = '0;
        expect_val("ch1_both_not_empty", S_NE, 2'b10);
        expect_val("ch1_both_block", S_BLK, 2'b00);
        check_pending();
        tick(1);
        bus.incr = '0;
        expect_val("ch1_cnt4_block", S_BLK, 2'b10);
        check_pending();
        bus.decr = 2'b10;
        tick(4);
        bus.decr = '0;
        expect_val("ch1_cnt0_empty", S_NE, 2'b00);
        check_pending();

        // Underflow on ch0, sticky across idle cycles.
        bus.decr = 2'b01;
        tick(1);
        bus.decr = '0;
        expect_val("ch0_uf_set", S_UF, 2'b01);
        expect_val("ch0_uf_not_empty", S_NE, 2'b00);
        check_pending();
        tick(10);
        expect_val("ch0_uf_sticky", S_UF, 2'b01);
        expect_val("ch0_of_sticky", S_OF, 2'b01);
        check_pending();

        // Drain handshake with ch0 at 2.
        bus.incr = 2'b01;
        tick(2);
        bus.incr      = '0;
        bus.drain_req = 1'b1;
        tick(1);
        expect_val("drain_block", S_BLK, 2'b11);
        expect_val("drain_no_ack", S_ACK, 0);
        check_pending();
        bus.decr = 2'b01;
        tick(2);
        bus.decr = '0;
        expect_val("drain_cnt0_no_ack", S_ACK, 0);
        expect_val("drain_cnt0_empty", S_NE, 2'b00);
        check_pending();
        tick(1);
        expect_val("drain_ack", S_ACK, 1);
        expect_val("drain_done_block", S_BLK, 2'b11);
        check_pending();
        bus.drain_req = 1'b0;
        tick(1);
        expect_val("drain_release_ack", S_ACK, 0);
        expect_val("drain_release_block", S_BLK, 2'b00);
        check_pending();

        // Reset in the middle of a drain with counts 3/1.
        bus.incr = 2'b11;
        tick(1);
        bus.incr = 2'b01;
        tick(2);
        bus.incr      = '0;
        bus.drain_req = 1'b1;
        tick(1);
        expect_val("mid_drain_block", S_BLK, 2'b11);
        check_pending();
        reset = 1'b1;
        tick(1);
        expect_val("mid_rst_block", S_BLK, 2'b00);
        expect_val("mid_rst_ack", S_ACK, 0);
        expect_val("mid_rst_not_empty", S_NE, 2'b00);
        expect_val("mid_rst_err_uf", S_UF, 2'b00);
        expect_val("mid_rst_err_of", S_OF, 2'b00);
        check_pending();
        bus.drain_req = 1'b0;
        reset         = 1'b0;
        tick(1);
        expect_val("post_rst_block", S_BLK, 2'b00);
        check_pending();

        // Peak tracking: 5 up, 3 down, then stats_clr.
        bus.incr = 2'b01;
        tick(5);
        bus.incr = '0;
        bus.decr = 2'b01;
        tick(3);
        bus.decr = '0;
        expect_val("peak_after_5up_3down", S_PK, STATS ? 32'd5 : 32'd0);
        check_pending();
        bus.stats_clr = 1'b1;
        tick(1);
        bus.stats_clr = 1'b0;
        expect_val("peak_after_clr", S_PK, STATS ? 32'd2 : 32'd0);
        expect_val("peak_cnt2_not_empty", S_NE, 2'b01);
        check_pending();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
